// File: rtl/rf_pkg.sv
// Shared register-file definitions: data width, register address width and
// the writeback requester identifiers used by the arbiter.
package rf_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: marks a destination busy at issue, frees it at
// writeback, and flags issue hazards on any busy source or destination.
module rf_scoreboard #(
    parameter int NREG = 32
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          issue_valid,
    input  logic [rf_pkg::REG_ADDR_W-1:0] issue_rd,
    input  logic [rf_pkg::REG_ADDR_W-1:0] issue_rs1,
    input  logic [rf_pkg::REG_ADDR_W-1:0] issue_rs2,
    input  logic                          wb_fire,
    input  logic [rf_pkg::REG_ADDR_W-1:0] wb_rd,
    output logic                          hazard,
    output logic [NREG-1:0]               busy_mask
);
    import rf_pkg::*;

    localparam int ADDR_SPAN = 1 << REG_ADDR_W;

    logic                 set_en;
    logic                 clr_en;
    logic [NREG-1:0]      set_vec;
    logic [NREG-1:0]      clr_vec;
    logic [ADDR_SPAN-1:0] busy_ext;

    // Widen to the full address span so every 5-bit index is in range.
    assign busy_ext = ADDR_SPAN'(busy_mask);
    assign hazard   = issue_valid &&
                      (busy_ext[issue_rs1] || busy_ext[issue_rs2] || busy_ext[issue_rd]);

    assign set_en  = issue_valid && !hazard && (issue_rd != '0);
    assign clr_en  = wb_fire && (wb_rd != '0);
    assign set_vec = set_en ? (NREG'(1) << issue_rd) : '0;
    assign clr_vec = clr_en ? (NREG'(1) << wb_rd) : '0;

    // Clear is applied before set, so a same-cycle issue to the same
    // register leaves it busy for the newer producer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_mask <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop
            // samples pre-edge values regardless of statement order.
            busy_mask <= ((busy_mask & ~clr_vec) | set_vec) & ~NREG'(1);
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates ALU and MEM writebacks onto the single register-file write port.
// Define WBARB_RR_EN for round-robin on contention; default is MEM-over-ALU.
module wb_port_arbiter #(
    parameter int XLEN = rf_pkg::XLEN,
    parameter int NREG = 32
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          alu_valid,
    input  logic [rf_pkg::REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]               alu_data,
    output logic                          alu_ready,
    input  logic                          mem_valid,
    input  logic [rf_pkg::REG_ADDR_W-1:0] mem_rd,
    input  logic [XLEN-1:0]               mem_data,
    output logic                          mem_ready,
    output logic                          rf_regwrite,
    output logic [rf_pkg::REG_ADDR_W-1:0] rf_write_reg,
    output logic [XLEN-1:0]               rf_write_data,
    input  logic                          issue_valid,
    input  logic [rf_pkg::REG_ADDR_W-1:0] issue_rd,
    input  logic [rf_pkg::REG_ADDR_W-1:0] issue_rs1,
    input  logic [rf_pkg::REG_ADDR_W-1:0] issue_rs2,
    output logic                          hazard,
    output logic [NREG-1:0]               busy_mask
);
    import rf_pkg::*;

    logic                  mem_first;
    logic                  alu_fire;
    logic                  mem_fire;
    logic                  wb_fire;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic [XLEN-1:0]       wb_data;

`ifdef WBARB_RR_EN
    req_e last_grant;

    assign mem_first = (last_grant == REQ_ALU);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_grant <= REQ_ALU;
        end else if (mem_fire) begin
            last_grant <= REQ_MEM;
        end else if (alu_fire) begin
            last_grant <= REQ_ALU;
        end
    end
`else
    assign mem_first = 1'b1;
`endif

    // Grants are mutually exclusive by construction; a lone valid wins at once.
    assign mem_ready = !reset && mem_valid && (!alu_valid || mem_first);
    assign alu_ready = !reset && alu_valid && !(mem_valid && mem_first);

    assign alu_fire = alu_valid && alu_ready;
    assign mem_fire = mem_valid && mem_ready;
    assign wb_fire  = alu_fire || mem_fire;

    always_comb begin
        // NOTE: defaults first so no path through this block leaves a signal
        // unassigned, which would infer a latch.
        wb_rd   = alu_rd;
        wb_data = alu_data;
        if (mem_fire) begin
            wb_rd   = mem_rd;
            wb_data = mem_data;
        end
    end

    // Writes to x0 are accepted so the requester drains, but never reach the RF.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rf_regwrite   <= 1'b0;
            rf_write_reg  <= '0;
            rf_write_data <= '0;
        end else begin
            rf_regwrite <= wb_fire && (wb_rd != '0);
            if (wb_fire) begin
                rf_write_reg  <= wb_rd;
                rf_write_data <= wb_data;
            end
        end
    end

    rf_scoreboard #(
        .NREG (NREG)
    ) u_scoreboard (
        .clock       (clock),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_rs1   (issue_rs1),
        .issue_rs2   (issue_rs2),
        .wb_fire     (wb_fire),
        .wb_rd       (wb_rd),
        .hazard      (hazard),
        .busy_mask   (busy_mask)
    );

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: vector table, directed corner
// sequences and a randomized run against a behavioural model.
module tb_wb_port_arbiter;

`ifdef WBARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic        alu_valid, mem_valid, issue_valid;
    logic [4:0]  alu_rd, mem_rd, issue_rd, issue_rs1, issue_rs2;
    logic [31:0] alu_data, mem_data;
    logic        alu_ready, mem_ready, rf_regwrite, hazard;
    logic [4:0]  rf_write_reg;
    logic [31:0] rf_write_data;
    logic [31:0] busy_mask;

    int vectors;
    int miscompares;

    wb_port_arbiter #(.XLEN(32), .NREG(32)) dut (
        .clock         (clock),
        .reset         (reset),
        .alu_valid     (alu_valid),
        .alu_rd        (alu_rd),
        .alu_data      (alu_data),
        .alu_ready     (alu_ready),
        .mem_valid     (mem_valid),
        .mem_rd        (mem_rd),
        .mem_data      (mem_data),
        .mem_ready     (mem_ready),
        .rf_regwrite   (rf_regwrite),
        .rf_write_reg  (rf_write_reg),
        .rf_write_data (rf_write_data),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .issue_rs1     (issue_rs1),
        .issue_rs2     (issue_rs2),
        .hazard        (hazard),
        .busy_mask     (busy_mask)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adat;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] mdat;
        logic        ex_ar;
        logic        ex_mr;
        logic        ex_we;
        logic [4:0]  ex_reg;
        logic [31:0] ex_data;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        alu_valid   = 1'b0; alu_rd   = '0; alu_data = '0;
        mem_valid   = 1'b0; mem_rd   = '0; mem_data = '0;
        issue_valid = 1'b0; issue_rd = '0; issue_rs1 = '0; issue_rs2 = '0;
    endtask

    // Leaves the caller one time unit after a rising edge.
    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    // Behavioural model state for the random phase.
    bit          m_busy[32];
    bit          m_mem_last;
    logic        exp_ar, exp_mr, exp_hz, exp_we;
    logic [4:0]  exp_reg, wrd;
    logic [31:0] exp_data, wdat, packed_busy;
    logic        a_acc, m_acc;

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        idle_inputs();

        // Reset state
        #3;
        check("reset_alu_ready", alu_ready, 1'b0);
        check("reset_mem_ready", mem_ready, 1'b0);
        check("reset_regwrite", rf_regwrite, 1'b0);
        check("reset_busy", busy_mask, 32'h0);
        do_reset();

        // Single-cycle vectors from an uncontended state
        tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b1, 5'd5,  32'hDEADBEEF};
        tbl[1] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd12, 32'hCAFEF00D, 1'b0, 1'b1, 1'b1, 5'd12, 32'hCAFEF00D};
        tbl[2] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 5'd0,  32'h0};
        tbl[3] = '{1'b1, 5'd0,  32'h00001234, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b0, 5'd0,  32'h0};
        tbl[4] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h00005678, 1'b0, 1'b1, 1'b0, 5'd0,  32'h0};
        tbl[5] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b1, 5'd31, 32'hFFFFFFFF};
        tbl[6] = '{1'b1, 5'd1,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b1, 5'd1,  32'h0};
        for (int i = 0; i < 7; i++) begin
            alu_valid = tbl[i].av; alu_rd = tbl[i].ard; alu_data = tbl[i].adat;
            mem_valid = tbl[i].mv; mem_rd = tbl[i].mrd; mem_data = tbl[i].mdat;
            @(negedge clock);
            check($sformatf("tbl%0d_alu_ready", i), alu_ready, tbl[i].ex_ar);
            check($sformatf("tbl%0d_mem_ready", i), mem_ready, tbl[i].ex_mr);
            @(posedge clock);
            #1;
            check($sformatf("tbl%0d_regwrite", i), rf_regwrite, tbl[i].ex_we);
            if (tbl[i].ex_we) begin
                check($sformatf("tbl%0d_reg", i), rf_write_reg, tbl[i].ex_reg);
                check($sformatf("tbl%0d_data", i), rf_write_data, tbl[i].ex_data);
            end
        end
        idle_inputs();

        // Contention for four cycles from reset
        do_reset();
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hAAAA0003;
        mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'hBBBB0004;
        for (int i = 0; i < 4; i++) begin
            logic exp_mem;
            exp_mem = RR ? ((i % 2) == 0) : 1'b1;
            @(negedge clock);
            check($sformatf("contend%0d_mem_ready", i), mem_ready, exp_mem);
            check($sformatf("contend%0d_alu_ready", i), alu_ready, !exp_mem);
            @(posedge clock);
            #1;
            check($sformatf("contend%0d_reg", i), rf_write_reg, exp_mem ? 5'd4 : 5'd3);
            check($sformatf("contend%0d_regwrite", i), rf_regwrite, 1'b1);
        end
        idle_inputs();

        // RAW hazard on r7 until MEM writes it back
        do_reset();
        issue_valid = 1'b1; issue_rd = 5'd7;
        @(negedge clock);
        check("raw_issue_hazard", hazard, 1'b0);
        @(posedge clock);
        #1;
        check("raw_busy7_set", busy_mask[7], 1'b1);
        issue_rd = 5'd0; issue_rs1 = 5'd7;
        repeat (2) begin
            @(negedge clock);
            check("raw_hazard_wait", hazard, 1'b1);
            @(posedge clock);
            #1;
        end
        mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h77777777;
        @(negedge clock);
        check("raw_hazard_at_wb", hazard, 1'b1);
        check("raw_mem_ready", mem_ready, 1'b1);
        @(posedge clock);
        #1;
        mem_valid = 1'b0;
        check("raw_busy7_clear", busy_mask[7], 1'b0);
        @(negedge clock);
        check("raw_hazard_cleared", hazard, 1'b0);
        @(posedge clock);
        #1;
        idle_inputs();

        // Same-cycle issue and writeback to r9
        do_reset();
        issue_valid = 1'b1; issue_rd = 5'd9;
        mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h99999999;
        @(negedge clock);
        check("same9_hazard", hazard, 1'b0);
        check("same9_mem_ready", mem_ready, 1'b1);
        @(posedge clock);
        #1;
        idle_inputs();
        check("same9_busy", busy_mask[9], 1'b1);
        check("same9_regwrite", rf_regwrite, 1'b1);
        check("same9_reg", rf_write_reg, 5'd9);

        // Register zero: accepted but never written, never busy
        do_reset();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h00001234;
        @(negedge clock);
        check("x0_alu_ready", alu_ready, 1'b1);
        @(posedge clock);
        #1;
        check("x0_regwrite", rf_regwrite, 1'b0);
        idle_inputs();
        issue_valid = 1'b1; issue_rd = 5'd0;
        @(negedge clock);
        check("x0_issue_hazard", hazard, 1'b0);
        @(posedge clock);
        #1;
        idle_inputs();
        check("x0_busy", busy_mask, 32'h0);

        // Reset the cycle after a handshake
        do_reset();
        issue_valid = 1'b1; issue_rd = 5'd6;
        @(posedge clock);
        #1;
        issue_valid = 1'b0;
        check("rst_busy6_before", busy_mask[6], 1'b1);
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h0BADF00D;
        mem_valid = 1'b0;
        @(negedge clock);
        check("rst_handshake", alu_ready, 1'b1);
        @(posedge clock);
        #1;
        reset = 1'b1;
        mem_valid = 1'b1; mem_rd = 5'd2;
        #1;
        check("rst_regwrite", rf_regwrite, 1'b0);
        check("rst_busy", busy_mask, 32'h0);
        check("rst_alu_ready", alu_ready, 1'b0);
        check("rst_mem_ready", mem_ready, 1'b0);
        @(negedge clock);
        check("rst_alu_ready_hold", alu_ready, 1'b0);
        check("rst_mem_ready_hold", mem_ready, 1'b0);
        idle_inputs();
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            check($sformatf("rst_release%0d_regwrite", i), rf_regwrite, 1'b0);
        end

        // Randomized traffic against the behavioural model
        do_reset();
        for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
        m_mem_last = 1'b0;
        a_acc = 1'b0;
        m_acc = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!alu_valid || a_acc) begin
                alu_valid = 1'($urandom_range(0, 1));
                alu_rd    = 5'($urandom_range(0, 7));
                alu_data  = $urandom;
            end
            if (!mem_valid || m_acc) begin
                mem_valid = 1'($urandom_range(0, 1));
                mem_rd    = 5'($urandom_range(0, 7));
                mem_data  = $urandom;
            end
            issue_valid = ($urandom_range(0, 9) < 4);
            issue_rd    = 5'($urandom_range(0, 7));
            issue_rs1   = 5'($urandom_range(0, 7));
            issue_rs2   = 5'($urandom_range(0, 7));

            @(negedge clock);
            // Lone valid wins; on contention MEM wins unless round-robin says it went last.
            exp_mr = mem_valid && (!alu_valid || !RR || !m_mem_last);
            exp_ar = alu_valid && !exp_mr;
            exp_hz = issue_valid && (m_busy[issue_rs1] || m_busy[issue_rs2] || m_busy[issue_rd]);
            check("rand_alu_ready", alu_ready, exp_ar);
            check("rand_mem_ready", mem_ready, exp_mr);
            check("rand_hazard", hazard, exp_hz);
            a_acc = exp_ar;
            m_acc = exp_mr;

            exp_we = 1'b0;
            if (a_acc || m_acc) begin
                wrd      = m_acc ? mem_rd : alu_rd;
                wdat     = m_acc ? mem_data : alu_data;
                exp_we   = (wrd != 5'd0);
                exp_reg  = wrd;
                exp_data = wdat;
                m_mem_last = m_acc;
                if (wrd != 5'd0) m_busy[wrd] = 1'b0;
            end
            if (issue_valid && !exp_hz && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;

            @(posedge clock);
            #1;
            check("rand_regwrite", rf_regwrite, exp_we);
            if (exp_we) begin
                check("rand_reg", rf_write_reg, exp_reg);
                check("rand_data", rf_write_data, exp_data);
            end
            for (int r = 0; r < 32; r++) packed_busy[r] = m_busy[r];
            check("rand_busy", busy_mask, packed_busy);
        end
        idle_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
